// File: rtl/qspi_psram_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_psram_slave_pkg
//  Description : Command codes, FSM state type and default sizing for the
//                QSPI PSRAM slave model.
//  Revision    : 1.0 - initial release
// ============================================================================
package qspi_psram_slave_pkg;

    localparam logic [7:0] CMD_WRITE_02 = 8'h02;
    localparam logic [7:0] CMD_WRITE_38 = 8'h38;
    localparam logic [7:0] CMD_READ_EB  = 8'hEB;

    localparam int DEFAULT_MEM_BYTES  = 8192;
    localparam int DEFAULT_READ_DUMMY = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_WDATA  = 3'd4,
        ST_RDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } qspi_state_e;

    function automatic logic is_write_cmd(input logic [7:0] cmd);
        return (cmd == CMD_WRITE_02) || (cmd == CMD_WRITE_38);
    endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_psram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_psram_slave
//  Description : Quad-SPI PSRAM slave with an inline byte array, quad write
//                (0x02/0x38) and quad read (0xEB) with dummy cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_psram_slave
    import qspi_psram_slave_pkg::*;
#(
    parameter int MEM_BYTES  = DEFAULT_MEM_BYTES,
    parameter int READ_DUMMY = DEFAULT_READ_DUMMY
) (
    input  logic       spi_clk,
    input  logic       rst,
    input  logic       spi_cs_n,
    input  logic [3:0] spi_data_in,
    output logic [3:0] spi_data_out,
    input  logic [3:0] spi_data_oe
);

    localparam int ADDR_W = $clog2(MEM_BYTES);
    localparam int CNT_W  = 8;

    // Chip-select release aborts a frame exactly like the system reset.
    logic w_arst;
    assign w_arst = rst | spi_cs_n;

    logic w_unused_oe;
    assign w_unused_oe = &spi_data_oe;

    qspi_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [6:0]        r_cmd, w_cmd_nxt;
    logic              r_is_rd, w_is_rd_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_phase, w_phase_nxt;
    logic [3:0]        r_hi, w_hi_nxt;
    logic              w_mem_we;
    logic [7:0]        w_cmd_full;
    logic [7:0]        r_mem [MEM_BYTES];
    logic [3:0]        r_dout;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cmd_nxt   = r_cmd;
        w_is_rd_nxt = r_is_rd;
        w_addr_nxt  = r_addr;
        w_phase_nxt = r_phase;
        w_hi_nxt    = r_hi;
        w_mem_we    = 1'b0;
        w_cmd_full  = {r_cmd, spi_data_in[0]};

        case (r_state)
            // IDLE consumes the first command bit on the first edge after CS.
            ST_IDLE, ST_CMD: begin
                w_cmd_nxt = w_cmd_full[6:0];
                if (r_cnt == CNT_W'(7)) begin
                    w_cnt_nxt   = '0;
                    w_is_rd_nxt = (w_cmd_full == CMD_READ_EB);
                    if (is_write_cmd(w_cmd_full) || (w_cmd_full == CMD_READ_EB))
                        w_state_nxt = ST_ADDR;
                    else
                        w_state_nxt = ST_IGNORE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_state_nxt = ST_CMD;
                end
            end
            ST_ADDR: begin
                // Upper address nibbles fall off the top of the shift register.
                w_addr_nxt = ADDR_W'({r_addr, spi_data_in});
                if (r_cnt == CNT_W'(5)) begin
                    w_cnt_nxt = '0;
                    if (!r_is_rd)
                        w_state_nxt = ST_WDATA;
                    else if (READ_DUMMY == 0)
                        w_state_nxt = ST_RDATA;
                    else
                        w_state_nxt = ST_DUMMY;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DUMMY: begin
                if (r_cnt == CNT_W'(READ_DUMMY - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RDATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WDATA: begin
                if (!r_phase) begin
                    w_hi_nxt    = spi_data_in;
                    w_phase_nxt = 1'b1;
                end else begin
                    w_mem_we    = 1'b1;
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_phase_nxt = 1'b0;
                end
            end
            ST_RDATA: begin
                // Phase tracks which nibble the next falling edge presents.
                w_phase_nxt = ~r_phase;
                if (r_phase)
                    w_addr_nxt = r_addr + ADDR_W'(1);
            end
            ST_IGNORE: begin
                w_state_nxt = ST_IGNORE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge spi_clk or posedge w_arst) begin
        if (w_arst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cmd   <= '0;
            r_is_rd <= 1'b0;
            r_addr  <= '0;
            r_phase <= 1'b0;
            r_hi    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cmd   <= w_cmd_nxt;
            r_is_rd <= w_is_rd_nxt;
            r_addr  <= w_addr_nxt;
            r_phase <= w_phase_nxt;
            r_hi    <= w_hi_nxt;
        end
    end

    always_ff @(posedge spi_clk) begin
        if (w_mem_we)
            r_mem[r_addr] <= {r_hi, spi_data_in};
    end

    always_ff @(negedge spi_clk or posedge w_arst) begin
        if (w_arst)
            r_dout <= 4'hF;
        else if (r_state == ST_RDATA)
            r_dout <= r_phase ? r_mem[r_addr][3:0] : r_mem[r_addr][7:4];
        else
            r_dout <= 4'hF;
    end

    assign spi_data_out = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_qspi_psram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qspi_psram_slave
//  Description : Randomized self-checking bench for qspi_psram_slave against a
//                byte-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qspi_psram_slave;

    localparam int MEM_BYTES  = 8192;
    localparam int READ_DUMMY = 6;

    logic       spi_clk = 1'b0;
    logic       rst;
    logic       spi_cs_n;
    logic [3:0] spi_data_in;
    logic [3:0] spi_data_oe;
    wire  [3:0] spi_data_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mdl [MEM_BYTES];
    bit         vld [MEM_BYTES];
    logic [3:0] rd_nibs [$];
    logic [7:0] wq [$];

    qspi_psram_slave #(
        .MEM_BYTES  (MEM_BYTES),
        .READ_DUMMY (READ_DUMMY)
    ) dut (
        .spi_clk      (spi_clk),
        .rst          (rst),
        .spi_cs_n     (spi_cs_n),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_data_oe  (spi_data_oe)
    );

    always #5 spi_clk = ~spi_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic edge1();
        @(posedge spi_clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        spi_data_in = n;
        edge1();
    endtask

    task automatic start_frame(input logic [7:0] cmd, input logic [23:0] addr);
        logic [7:0]  c;
        logic [23:0] a;
        c = cmd;
        a = addr;
        spi_cs_n    = 1'b0;
        spi_data_oe = 4'hF;
        for (int i = 7; i >= 0; i--) send_nib({3'b000, c[i]});
        for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
    endtask

    task automatic end_frame();
        spi_cs_n    = 1'b1;
        spi_data_oe = 4'h0;
        #1;
        check("cs_high_idle", {28'd0, spi_data_out}, 32'hF);
        edge1();
    endtask

    task automatic write_burst(input logic [7:0] cmd, input logic [23:0] addr, input logic [7:0] data [$]);
        int unsigned a;
        start_frame(cmd, addr);
        for (int i = 0; i < data.size(); i++) begin
            send_nib(data[i][7:4]);
            send_nib(data[i][3:0]);
            a = (int'(addr) + i) % MEM_BYTES;
            mdl[a] = data[i];
            vld[a] = 1'b1;
        end
        end_frame();
    endtask

    task automatic read_burst(input logic [23:0] addr, input int n);
        int unsigned a;
        logic [3:0]  got;
        rd_nibs.delete();
        start_frame(8'hEB, addr);
        spi_data_oe = 4'h0;
        for (int d = 0; d < READ_DUMMY; d++) begin
            send_nib(4'($urandom));
            check("dummy_pullup", {28'd0, spi_data_out}, 32'hF);
        end
        for (int i = 0; i < n; i++) begin
            a = (int'(addr) + i) % MEM_BYTES;
            for (int h = 0; h < 2; h++) begin
                edge1();
                got = spi_data_out;
                rd_nibs.push_back(got);
                if (vld[a])
                    check(h == 0 ? "rd_hi" : "rd_lo", {28'd0, got},
                          {28'd0, (h == 0) ? mdl[a][7:4] : mdl[a][3:0]});
            end
        end
        end_frame();
    endtask

    // Frame cut short after k nibble clocks; memory must be untouched.
    task automatic abort_frame(input logic [7:0] cmd, input logic [23:0] addr, input int k);
        logic [7:0]  c;
        logic [23:0] a;
        c = cmd;
        a = addr;
        spi_cs_n    = 1'b0;
        spi_data_oe = 4'hF;
        for (int i = 0; i < k; i++) begin
            if (i < 8)       send_nib({3'b000, c[7-i]});
            else if (i < 14) send_nib(a[(13-i)*4 +: 4]);
            else             send_nib(4'($urandom));
        end
        end_frame();
    endtask

    initial begin
        logic [23:0] addr;
        int          len;
        logic [23:0] last_wr;

        rst         = 1'b1;
        spi_cs_n    = 1'b1;
        spi_data_in = 4'h0;
        spi_data_oe = 4'h0;
        for (int i = 0; i < MEM_BYTES; i++) vld[i] = 1'b0;

        edge1();
        check("reset_out", {28'd0, spi_data_out}, 32'hF);
        spi_cs_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_nib(4'hE);
            check("reset_cs_low_out", {28'd0, spi_data_out}, 32'hF);
        end
        spi_cs_n = 1'b1;
        edge1();
        rst = 1'b0;

        // First frame after reset release: basic write then read.
        wq = {8'hA5};
        write_burst(8'h38, 24'h000010, wq);
        read_burst(24'h000010, 1);
        check("basic_hi", {28'd0, rd_nibs[0]}, 32'hA);
        check("basic_lo", {28'd0, rd_nibs[1]}, 32'h5);

        // Burst across the top of memory.
        wq = {8'h11, 8'h22, 8'h33};
        write_burst(8'h02, 24'h001FFF, wq);
        read_burst(24'h001FFF, 3);
        check("wrap_b0", {28'd0, rd_nibs[0], rd_nibs[1]}, 32'h11);
        check("wrap_b1", {28'd0, rd_nibs[2], rd_nibs[3]}, 32'h22);
        check("wrap_b2", {28'd0, rd_nibs[4], rd_nibs[5]}, 32'h33);

        // Unknown command followed by a write-looking payload.
        spi_cs_n    = 1'b0;
        spi_data_oe = 4'hF;
        for (int i = 7; i >= 0; i--) begin
            send_nib({3'b000, i[0] ^ i[1] ? 1'b1 : (i >= 6) || (i < 1)});
            check("ign_cmd_pullup", {28'd0, spi_data_out}, 32'hF);
        end
        addr = 24'h000010;
        for (int i = 0; i < 20; i++) begin
            send_nib(i < 6 ? addr[(5-i)*4 +: 4] : 4'h0);
            check("ign_pullup", {28'd0, spi_data_out}, 32'hF);
        end
        end_frame();
        read_burst(24'h000010, 1);
        check("ign_keep_hi", {28'd0, rd_nibs[0]}, 32'hA);
        check("ign_keep_lo", {28'd0, rd_nibs[1]}, 32'h5);

        // Half byte cut by CS release.
        wq = {8'h5A};
        write_burst(8'h02, 24'h000020, wq);
        abort_frame(8'h02, 24'h000020, 15);
        read_burst(24'h000020, 1);
        check("partial_keep", {28'd0, rd_nibs[0], rd_nibs[1]}, 32'h5A);

        // Reset in the middle of a read burst.
        start_frame(8'hEB, 24'h000010);
        spi_data_oe = 4'h0;
        for (int d = 0; d < READ_DUMMY; d++) send_nib(4'h0);
        edge1();
        check("rst_mid_first", {28'd0, spi_data_out}, 32'hA);
        rst = 1'b1;
        #1;
        check("rst_mid_out", {28'd0, spi_data_out}, 32'hF);
        spi_cs_n = 1'b1;
        edge1();
        check("rst_hold_out", {28'd0, spi_data_out}, 32'hF);
        rst = 1'b0;
        edge1();
        read_burst(24'h000010, 1);
        check("post_rst_rd", {28'd0, rd_nibs[0], rd_nibs[1]}, 32'hA5);

        // High address bits are dropped.
        wq = {8'hC3};
        write_burst(8'h38, 24'h802040, wq);
        read_burst(24'h000040, 1);
        check("addr_map", {28'd0, rd_nibs[0], rd_nibs[1]}, 32'hC3);

        // Randomized traffic against the model.
        last_wr = 24'h000100;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    addr = ($urandom_range(0, 3) == 0)
                         ? 24'(MEM_BYTES - $urandom_range(1, 4)) | (24'($urandom_range(0, 255)) << 16)
                         : 24'($urandom);
                    len = $urandom_range(1, 6);
                    wq.delete();
                    for (int b = 0; b < len; b++) wq.push_back(8'($urandom));
                    write_burst($urandom_range(0, 1) ? 8'h02 : 8'h38, addr, wq);
                    last_wr = addr;
                end
                1: read_burst(last_wr, $urandom_range(1, 6));
                2: abort_frame($urandom_range(0, 1) ? 8'h02 : 8'hEB, last_wr, $urandom_range(1, 15));
                default: read_burst(24'($urandom_range(0, 15)) + last_wr, $urandom_range(1, 4));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
